// File: rtl/nand_tree_pipe.sv
// Purpose: N-input NAND reduction (~&in_data) as a balanced NAND/invert tree, registered every LVL_PER_STG levels.
// Latency: S = ceil(ceil(log2 N)/LVL_PER_STG) cycles from the accept cycle to out_valid; 1 word/cycle throughput.
// Backpressure: per-stage valid/ready; bubbles fill under stall, in_ready drops only when every stage is full.
// Optional: define STATS_EN to add stat_cnt_o, a saturating count of delivered results with out_y == 0.
module nand_tree_pipe #(
    parameter int N           = 8,
    parameter int LVL_PER_STG = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [N-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic         out_y_o
`ifdef STATS_EN
    ,
    output logic [15:0]  stat_cnt_o
`endif
);

    localparam int L  = $clog2(N);
    localparam int PW = 1 << L;
    localparam int S  = (L + LVL_PER_STG - 1) / LVL_PER_STG;

    // Operand padded to a power of two with ones, which are neutral for AND.
    logic [PW-1:0] pad_in;

    // adv[k]: stage k may load this cycle; adv[S] is the consumer's ready.
    logic [S:0]   adv;
    logic [S-1:0] v_q;
    logic [S-1:0] v_d;

    // Pad the operand with ones up to the tree width.
    always_comb begin
        pad_in         = '1;
        pad_in[N-1:0]  = in_data_i;
    end

    assign adv[S] = out_ready_i;

    for (genvar k = 0; k < S; k++) begin : g_adv
        assign adv[k] = ~v_q[k] | adv[k+1];
    end

    assign in_ready_o = adv[0];

    // Valid bits shift forward wherever a stage advances; an empty upstream moves a bubble in.
    always_comb begin
        v_d = v_q;
        if (adv[0]) begin
            v_d[0] = in_valid_i;
        end
        for (int k = 1; k < S; k++) begin
            if (adv[k]) begin
                v_d[k] = v_q[k-1];
            end
        end
    end

    // Stage valid registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    for (genvar k = 0; k < S; k++) begin : g_stg
        localparam int FL = k * LVL_PER_STG;
        localparam int LL = ((k + 1) * LVL_PER_STG > L) ? L : (k + 1) * LVL_PER_STG;
        localparam int NL = LL - FL;
        localparam int WI = PW >> FL;
        localparam int WO = PW >> LL;

        // ch packs this stage's input vector followed by each level's output, narrowest last.
        logic [2*WI-WO-1:0] ch;
        logic               ld;
        logic [WO-1:0]      d_d;
        logic [WO-1:0]      d_q;

        // Data only loads when a real word moves in, so idle inputs never disturb the registers.
        if (k == 0) begin : g_src
            assign ch[WI-1:0] = pad_in;
            assign ld         = adv[0] & in_valid_i;
        end else begin : g_src
            assign ch[WI-1:0] = g_stg[k-1].d_q;
            assign ld         = adv[k] & v_q[k-1];
        end

        for (genvar j = 1; j <= NL; j++) begin : g_lvl
            localparam int WJ = WI >> j;
            localparam int OI = 2*WI - 2*(WI >> (j-1));
            localparam int OO = 2*WI - 2*WJ;
            for (genvar i = 0; i < WJ; i++) begin : g_gate
                logic nd;
                assign nd = ~(ch[OI+2*i] & ch[OI+2*i+1]);
                // The root keeps the NAND; inner levels re-invert to form AND.
                if (FL + j == L) begin : g_root
                    assign ch[OO+i] = nd;
                end else begin : g_inv
                    assign ch[OO+i] = ~(nd & nd);
                end
            end
        end

        assign d_d = ch[2*WI-WO-1 -: WO];

        // Stage partial-vector register.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                d_q <= '0;
            end else if (ld) begin
                d_q <= d_d;
            end
        end
    end

    assign out_valid_o = v_q[S-1];
    assign out_y_o     = g_stg[S-1].d_q[0];

`ifdef STATS_EN
    logic [15:0] stat_q;

    // Count delivered all-ones words (out_y == 0), saturating at the top.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_q <= '0;
        end else if (out_valid_o && out_ready_i && !out_y_o && (stat_q != 16'hFFFF)) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign stat_cnt_o = stat_q;
`endif

endmodule

// File: tb/tb_nand_tree_pipe.sv
// Directed bench for nand_tree_pipe: N=8/LPS=1 instance (a_*) and N=5/LPS=2 instance (b_*).
// Latency is counted in cycles from the handshake cycle to the first cycle showing out_valid.
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
module tb_nand_tree_pipe;

    logic       clk = 1'b0;
    logic       rst;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_y;
    logic [7:0] a_in_data;
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_y;
    logic [4:0] b_in_data;
`ifdef STATS_EN
    logic [15:0] a_stat;
    logic [15:0] b_stat;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int lat;

    logic [7:0] sw [4];
    logic       sy [4];
    logic [7:0] ww [5];
    logic       wy [5];

    always #5 clk = ~clk;

    nand_tree_pipe #(.N(8), .LVL_PER_STG(1)) u_a (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (a_in_valid),
        .in_ready_o  (a_in_ready),
        .in_data_i   (a_in_data),
        .out_valid_o (a_out_valid),
        .out_ready_i (a_out_ready),
        .out_y_o     (a_out_y)
`ifdef STATS_EN
        ,
        .stat_cnt_o  (a_stat)
`endif
    );

    nand_tree_pipe #(.N(5), .LVL_PER_STG(2)) u_b (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (b_in_valid),
        .in_ready_o  (b_in_ready),
        .in_data_i   (b_in_data),
        .out_valid_o (b_out_valid),
        .out_ready_i (b_out_ready),
        .out_y_o     (b_out_y)
`ifdef STATS_EN
        ,
        .stat_cnt_o  (b_stat)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sw = '{8'hFF, 8'h7F, 8'hFF, 8'h00};
        sy = '{1'b0, 1'b1, 1'b0, 1'b1};
        ww = '{8'hFF, 8'h7E, 8'h00, 8'hFF, 8'hEF};
        wy = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset held for two cycles.
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = 5'h00; b_out_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_out_y", a_out_y, 1'b0);
        chk("rst_in_ready", a_in_ready, 1'b1);
        chk("rst_b_out_valid", b_out_valid, 1'b0);
`ifdef STATS_EN
        chk("rst_stat", a_stat, 16'd0);
`endif

        // Single all-ones word: NAND = 0 after 3 cycles, one beat only.
        a_in_valid = 1'b1; a_in_data = 8'hFF;
        #1;
        chk("single_in_ready", a_in_ready, 1'b1);
        tick();
        a_in_valid = 1'b0;
        lat = 1;
        while (!a_out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("single_latency", lat, 3);
        chk("single_y", a_out_y, 1'b0);
        tick();
        chk("single_one_beat", a_out_valid, 1'b0);

        // Back-to-back stream FF,7F,FF,00 -> 0,1,0,1 on consecutive cycles.
        for (int c = 0; c < 7; c++) begin
            if (c < 4) begin
                a_in_valid = 1'b1;
                a_in_data  = sw[c];
            end else begin
                a_in_valid = 1'b0;
            end
            tick();
            if (c >= 2 && c < 6) begin
                chk($sformatf("stream_valid_%0d", c - 2), a_out_valid, 1'b1);
                chk($sformatf("stream_y_%0d", c - 2), a_out_y, sy[c-2]);
            end
        end
        chk("stream_drained", a_out_valid, 1'b0);
`ifdef STATS_EN
        // One zero result from the single-word test plus two from the stream.
        chk("stream_stat", a_stat, 16'd3);
`endif

        // Stall: three words fill the pipe, the fourth is refused, output held.
        a_out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            a_in_valid = 1'b1;
            a_in_data  = ww[c];
            #1;
            chk($sformatf("stall_fill_rdy_%0d", c), a_in_ready, 1'b1);
            tick();
        end
        a_in_data = ww[3];
        #1;
        chk("stall_full_rdy", a_in_ready, 1'b0);
        chk("stall_out_valid", a_out_valid, 1'b1);
        chk("stall_out_y", a_out_y, wy[0]);
        tick();
        chk("stall_hold_y", a_out_y, wy[0]);
        chk("stall_hold_valid", a_out_valid, 1'b1);
        chk("stall_hold_rdy", a_in_ready, 1'b0);

        // Release: accept and deliver in the same cycle, all five words leave with no gap.
        a_out_ready = 1'b1;
        #1;
        chk("release_rdy", a_in_ready, 1'b1);
        for (int d = 0; d < 5; d++) begin
            if (d < 2) begin
                a_in_valid = 1'b1;
                a_in_data  = ww[3+d];
            end else begin
                a_in_valid = 1'b0;
            end
            #1;
            chk($sformatf("release_valid_%0d", d), a_out_valid, 1'b1);
            chk($sformatf("release_y_%0d", d), a_out_y, wy[d]);
            tick();
        end
        chk("release_drained", a_out_valid, 1'b0);
`ifdef STATS_EN
        chk("release_stat", a_stat, 16'd5);
`endif

        // Mid-flight reset discards two accepted words.
        for (int c = 0; c < 2; c++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'hFF;
            tick();
        end
        a_in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("midrst_valid_%0d", c), a_out_valid, 1'b0);
            tick();
        end
        chk("midrst_in_ready", a_in_ready, 1'b1);
`ifdef STATS_EN
        chk("midrst_stat", a_stat, 16'd0);
`endif

        // N=5, LVL_PER_STG=2: two stages.
        b_in_valid = 1'b1; b_in_data = 5'h1F;
        #1;
        chk("b_in_ready", b_in_ready, 1'b1);
        tick();
        b_in_valid = 1'b0;
        lat = 1;
        while (!b_out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("b_1f_latency", lat, 2);
        chk("b_1f_y", b_out_y, 1'b0);
        tick();
        chk("b_1f_one_beat", b_out_valid, 1'b0);

        b_in_valid = 1'b1; b_in_data = 5'h1E;
        tick();
        b_in_valid = 1'b0;
        lat = 1;
        while (!b_out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("b_1e_latency", lat, 2);
        chk("b_1e_y", b_out_y, 1'b1);
        tick();

        // Back-to-back pair 1F,10 -> 0,1.
        for (int c = 0; c < 4; c++) begin
            if (c == 0) begin
                b_in_valid = 1'b1; b_in_data = 5'h1F;
            end else if (c == 1) begin
                b_in_valid = 1'b1; b_in_data = 5'h10;
            end else begin
                b_in_valid = 1'b0;
            end
            tick();
            if (c == 1) chk("b_stream_y0", b_out_y, 1'b0);
            if (c == 2) chk("b_stream_y1", b_out_y, 1'b1);
            if (c >= 1 && c <= 2) chk($sformatf("b_stream_valid_%0d", c), b_out_valid, 1'b1);
        end
        chk("b_stream_drained", b_out_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
